booth_mac_sequencer: RTL
========================

Name: booth_mac_sequencer

Overview:
Sequences one shared radix-4 Booth multiplier / Wallace-tree datapath (signed DWIDTH x DWIDTH in, redundant sum/carry rows out) through a dot product of cfg_len operand pairs. Accepts pairs over a valid/ready stream, pipelines the sum/carry rows, resolves them and accumulates into a wide signed accumulator. Returns the result over a valid/ready output. Sits between the TensorCore operand feeder and the Kulisch accumulator stage.

Parameters:
DWIDTH, 11, operand width (signed, two's complement); passed to the multiplier instance.
ACC_WIDTH, 48, accumulator width; must be >= 2*DWIDTH.
LEN_WIDTH, 8, width of the element-count configuration.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  launch a dot product; sampled only in IDLE.
cfg_len  input  LEN_WIDTH  number of pairs; sampled with start.
busy  output  1  high in any state other than IDLE.
in_valid  input  1  operand pair valid.
in_ready  output  1  sequencer accepts a pair this cycle.
in_a  input  DWIDTH  signed multiplicand.
in_b  input  DWIDTH  signed multiplier.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts the result.
out_acc  output  ACC_WIDTH  signed dot-product result.
out_overflow  output  1  sticky: the accumulator wrapped during this job.

Behaviour:
- Reset (async, active-high): state=IDLE; busy, in_ready, out_valid, out_overflow=0; out_acc=0; element counter, pipeline valid and length register cleared. Reset mid-job aborts it; nothing is emitted.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: on start=1, latch cfg_len and clear acc, overflow and counter. Go to RUN if cfg_len!=0. If cfg_len==0, go to DONE with out_acc=0.
- RUN: in_ready = (count < len). A pair transfers when in_valid && in_ready. Each transfer increments count. When the transfer with count==len-1 occurs, go to DRAIN. in_valid while in_ready=0 is ignored. Inputs must be held stable by the producer until they transfer.
- Stage 1: the multiplier instance is combinational on in_a/in_b. On transfer, register its sum and carry rows (2*DWIDTH each) with s1_valid=1. Otherwise s1_valid=0.
- Stage 2: when s1_valid=1, compute prod = (sum + carry) mod 2^(2*DWIDTH). This is the exact signed product. Sign-extend prod to ACC_WIDTH and add to acc, wrapping mod 2^ACC_WIDTH.
- Overflow: set out_overflow if the operands of the add have equal signs and the result sign differs. The flag is sticky until the next start.
- DRAIN: on the edge that accumulates the final product, go to DONE. Throughput is one pair per cycle. Latency is 2 edges from the final transfer edge to out_valid=1.
- DONE: out_valid=1 and out_acc/out_overflow stable. When out_valid && out_ready, go to IDLE; out_valid drops the next cycle. out_acc keeps its value until the next start.
- start outside IDLE is ignored, including in DONE in the same cycle as the output handshake. start is accepted no earlier than the cycle after the return to IDLE.
- cfg_len changes outside IDLE have no effect.
- Maximum job length is cfg_len = 2^LEN_WIDTH-1. The counter must not wrap.
- busy = (state != IDLE).

Test Plan:
- Basic: DWIDTH=11, start with cfg_len=3, pairs (3,4),(-5,6),(7,-8) back-to-back -> out_acc=-74, out_overflow=0, out_valid exactly 2 edges after the 3rd transfer.
- Corner operands: cfg_len=2, pairs (-1024,-1024),(1023,-1024) -> out_acc=1048576-1047552=1024. Also a single pair (-1024,1023) -> -1047552. Checks the Booth sign handling.
- Backpressure and gaps: cfg_len=4, in_valid toggled randomly; hold out_ready=0 for 5 cycles in DONE -> same result as the gapless run; out_acc stable and out_valid held; exactly 4 transfers; in_ready=0 after the 4th.
- Zero length and ignored start: cfg_len=0 -> DONE with out_acc=0 the cycle after start, no in_ready. start pulses during RUN/DONE -> no effect on count or result.
- Overflow: ACC_WIDTH=24, cfg_len=9, all pairs (-1024,-1024) -> out_acc=-7340032 (9437184 wrapped), out_overflow=1. Next job (2,3), cfg_len=1 -> out_acc=6, out_overflow=0.
- Reset mid-job: assert rst after 2 of 5 transfers -> all outputs 0 and state IDLE immediately. A new job cfg_len=1 with pair (5,5) -> out_acc=25.

Source files
------------

// File: rtl/booth_mac_sequencer_if.sv
// Stream/control bundle for booth_mac_sequencer.
//   start/cfg_len      : job launch and element count (sampled in IDLE only)
//   busy               : sequencer is not idle
//   in_valid/in_ready  : operand-pair handshake carrying in_a/in_b (signed)
//   out_valid/out_ready: result handshake carrying out_acc/out_overflow
// master = operand feeder / result consumer side, slave = the sequencer.
interface booth_mac_sequencer_if #(
    parameter int DWIDTH    = 11,
    parameter int ACC_WIDTH = 48,
    parameter int LEN_WIDTH = 8
);
    logic                        start;
    logic [LEN_WIDTH-1:0]        cfg_len;
    logic                        busy;
    logic                        in_valid;
    logic                        in_ready;
    logic signed [DWIDTH-1:0]    in_a;
    logic signed [DWIDTH-1:0]    in_b;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [ACC_WIDTH-1:0] out_acc;
    logic                        out_overflow;

    modport master (
        output start, cfg_len, in_valid, in_a, in_b, out_ready,
        input  busy, in_ready, out_valid, out_acc, out_overflow
    );

    modport slave (
        input  start, cfg_len, in_valid, in_a, in_b, out_ready,
        output busy, in_ready, out_valid, out_acc, out_overflow
    );
endinterface

// File: rtl/booth_mac_sequencer.sv
// Dot-product sequencer around a radix-4 Booth / carry-save multiplier.
// Operand pairs stream in over bus.in_*, the multiplier's redundant
// sum/carry rows are registered (stage 1), then resolved and added into a
// wrapping signed accumulator (stage 2). The result and a sticky signed
// overflow flag are held on bus.out_* until the consumer accepts them.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, aborts any job in flight
//   bus : booth_mac_sequencer_if slave modport (see interface header)
module booth_mac_sequencer #(
    parameter int DWIDTH    = 11,
    parameter int ACC_WIDTH = 48,
    parameter int LEN_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    booth_mac_sequencer_if.slave  bus
);
    localparam int PW = 2 * DWIDTH;        // product / row width
    localparam int NB = (DWIDTH + 1) / 2;  // number of radix-4 Booth digits

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    // ---------------------------------------------------------------
    // Booth multiplier: partial products plus 3:2 carry-save reduction
    // ---------------------------------------------------------------
    logic [PW-1:0]          a_ext;
    logic signed [2*NB-1:0] b_sx;
    logic [2*NB:0]          b_ext;   // multiplier with implicit b[-1]=0
    logic [NB-1:0][PW-1:0]  pp;
    logic [PW-1:0]          mult_sum;
    logic [PW-1:0]          mult_carry;

    assign a_ext = PW'(bus.in_a);
    assign b_sx  = (2 * NB)'(bus.in_b);
    assign b_ext = {b_sx, 1'b0};

    // Digit in {-2..+2} from an overlapping 3-bit group; negatives are full
    // two's complement here, so no separate +1 correction row is needed.
    function automatic logic [PW-1:0] booth_pp(input logic [2:0] grp,
                                               input logic [PW-1:0] a);
        logic [PW-1:0] r;
        r = '0;
        case (grp)
            3'b001, 3'b010: r = a;
            3'b011:         r = a << 1;
            3'b100:         r = -(a << 1);
            3'b101, 3'b110: r = -a;
            default:        r = '0;
        endcase
        return r;
    endfunction

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_pp
            assign pp[gi] = booth_pp(b_ext[2*gi+2 -: 3], a_ext) << (2 * gi);
        end
    endgenerate

    // Reduce all partial products to two rows; the rows sum (mod 2^PW)
    // to the exact signed product.
    always_comb begin
        logic [PW-1:0] s_row;
        logic [PW-1:0] c_row;
        logic [PW-1:0] t_row;
        s_row = pp[0];
        c_row = '0;
        t_row = '0;
        for (int i = 1; i < NB; i++) begin
            t_row = s_row ^ c_row ^ pp[i];
            c_row = ((s_row & c_row) | (s_row & pp[i]) | (c_row & pp[i])) << 1;
            s_row = t_row;
        end
        mult_sum   = s_row;
        mult_carry = c_row;
    end

    // ---------------------------------------------------------------
    // Sequencer state and pipeline
    // ---------------------------------------------------------------
    state_t                state_reg;
    logic [LEN_WIDTH-1:0]  len_reg;
    logic [LEN_WIDTH-1:0]  count_reg;
    logic                  s1_valid_reg;
    logic [PW-1:0]         s1_sum_reg;
    logic [PW-1:0]         s1_carry_reg;
    logic [ACC_WIDTH-1:0]  acc_reg;
    logic                  overflow_reg;
    logic                  in_ready_reg;
    logic                  out_valid_reg;
    logic                  busy_reg;

    logic                  transfer;
    logic [PW-1:0]         prod;
    logic [ACC_WIDTH-1:0]  prod_ext;
    logic [ACC_WIDTH-1:0]  acc_next;
    logic                  add_ovf;

    // in_ready is only ever set while in RUN, so this implies RUN.
    assign transfer = bus.in_valid && in_ready_reg;

    assign prod     = s1_sum_reg + s1_carry_reg;
    assign prod_ext = ACC_WIDTH'(signed'(prod));
    assign acc_next = acc_reg + prod_ext;
    assign add_ovf  = (acc_reg[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                      (acc_next[ACC_WIDTH-1] != acc_reg[ACC_WIDTH-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            len_reg       <= '0;
            count_reg     <= '0;
            s1_valid_reg  <= 1'b0;
            s1_sum_reg    <= '0;
            s1_carry_reg  <= '0;
            acc_reg       <= '0;
            overflow_reg  <= 1'b0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            s1_valid_reg <= transfer;
            if (transfer) begin
                s1_sum_reg   <= mult_sum;
                s1_carry_reg <= mult_carry;
            end

            if (s1_valid_reg) begin
                acc_reg <= acc_next;
                if (add_ovf) begin
                    overflow_reg <= 1'b1;
                end
            end

            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        len_reg      <= bus.cfg_len;
                        count_reg    <= '0;
                        acc_reg      <= '0;
                        overflow_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        if (bus.cfg_len != '0) begin
                            state_reg    <= RUN;
                            in_ready_reg <= 1'b1;
                        end else begin
                            state_reg     <= DONE;
                            out_valid_reg <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (transfer) begin
                        count_reg <= count_reg + 1'b1;
                        if (count_reg == len_reg - 1'b1) begin
                            state_reg    <= DRAIN;
                            in_ready_reg <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    // The last product is accumulated on this same edge.
                    if (s1_valid_reg) begin
                        state_reg     <= DONE;
                        out_valid_reg <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy         = busy_reg;
    assign bus.in_ready     = in_ready_reg;
    assign bus.out_valid    = out_valid_reg;
    assign bus.out_acc      = acc_reg;
    assign bus.out_overflow = overflow_reg;
endmodule
